// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler draining two show-ahead VC FIFOs onto one
// output link: up to W0 consecutive VC0 grants, then up to W1 VC1 grants.
module vc_wrr_scheduler #(
  parameter int DATA_WIDTH = 6,
  parameter int W0         = 4,
  parameter int W1         = 1,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vc0_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  out_almost_full,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  grant_vc,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a FIFO word is consumed in exactly the cycle its pop strobe is
  // high; the same word appears on data_out with valid_out one cycle later.
  // There is no ready input: out_almost_full only suppresses future pops.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] W0_LAST = CNT_WIDTH'(W0 - 1);
  localparam logic [CNT_WIDTH-1:0] W1_LAST = CNT_WIDTH'(W1 - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    grant_q;
  logic                    stall;

  assign stall = out_almost_full;

  // Reset gating keeps the strobes quiet even before state_q has settled.
  assign pop_vc0 = !reset && (state_q == SERVE0) && !vc0_empty && !stall;
  assign pop_vc1 = !reset && (state_q == SERVE1) && !vc1_empty && !stall;

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_vc  = grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!vc0_empty)      state_d = SERVE0;
        else if (!vc1_empty) state_d = SERVE1;
        else                 state_d = IDLE;
      end
      SERVE0: begin
        if (stall) begin
          state_d = SERVE0;
        end else if (pop_vc0) begin
          if (cnt_q == W0_LAST) begin
            cnt_d   = '0;
            state_d = vc1_empty ? SERVE0 : SERVE1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          state_d = vc1_empty ? IDLE : SERVE1;
        end
      end
      SERVE1: begin
        if (stall) begin
          state_d = SERVE1;
        end else if (pop_vc1) begin
          if (cnt_q == W1_LAST) begin
            cnt_d   = '0;
            state_d = vc0_empty ? SERVE1 : SERVE0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          state_d = vc0_empty ? IDLE : SERVE0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage: data and grant hold between pops, valid is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= 1'b0;
    end else if (pop_vc0) begin
      data_q  <= vc0_data;
      valid_q <= 1'b1;
      grant_q <= 1'b0;
    end else if (pop_vc1) begin
      data_q  <= vc1_data;
      valid_q <= 1'b1;
      grant_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Directed bench for vc_wrr_scheduler: queue-backed FIFO models feed the DUT,
// every check compares against hand-derived cycle-by-cycle expectations.
module tb_vc_wrr_scheduler;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         vc0_empty, vc1_empty;
  logic [W-1:0] vc0_data, vc1_data;
  logic         out_almost_full = 1'b0;
  logic         pop_vc0, pop_vc1;
  logic [W-1:0] data_out;
  logic         valid_out, grant_vc, busy;
  logic [1:0]   dbg_state;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] exp_q[$];
  logic         refill0 = 1'b0;
  logic         refill1 = 1'b0;
  logic [3:0]   next0 = 4'd1;
  int           checks = 0;
  int           failures = 0;
  int           pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  vc_wrr_scheduler #(.DATA_WIDTH(W), .W0(4), .W1(1), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .vc0_empty(vc0_empty), .vc0_data(vc0_data),
    .vc1_empty(vc1_empty), .vc1_data(vc1_data),
    .out_almost_full(out_almost_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .valid_out(valid_out), .grant_vc(grant_vc),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive_fifo();
    if (refill0) while (q0.size() < 2) begin q0.push_back({2'b00, next0}); next0++; end
    if (refill1) while (q1.size() < 2) q1.push_back(6'h32);
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = (q0.size() != 0) ? q0[0] : '0;
    vc1_data  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // Advance one cycle; leaves the bench 2 time units after the rising edge.
  task automatic tick();
    logic p0, p1;
    p0 = pop_vc0;
    p1 = pop_vc1;
    @(posedge clk);
    #1;
    if (p0 && q0.size() != 0) void'(q0.pop_front());
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    drive_fifo();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_almost_full = 1'b0;
    refill0 = 1'b0;
    refill1 = 1'b0;
    q0.delete();
    q1.delete();
    drive_fifo();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Test 1: reset with both FIFOs non-empty
    q0.push_back(6'h11); q0.push_back(6'h14); q1.push_back(6'h32);
    drive_fifo();
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_pop0", pop_vc0, 0);
      check("rst_pop1", pop_vc1, 0);
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 0);
      check("rst_busy", busy, 0);
      tick();
    end

    // Test 2: two VC0 words, VC1 empty
    q1.delete();
    drive_fifo();
    reset = 1'b0;
    #1;
    check("t2_c0_busy", busy, 0);
    check("t2_c0_pop0", pop_vc0, 0);
    tick();
    check("t2_c1_busy", busy, 1);
    check("t2_c1_pop0", pop_vc0, 1);
    check("t2_c1_valid", valid_out, 0);
    tick();
    check("t2_c2_pop0", pop_vc0, 1);
    check("t2_c2_valid", valid_out, 1);
    check("t2_c2_data", data_out, 6'h11);
    check("t2_c2_grant", grant_vc, 0);
    tick();
    check("t2_c3_pop0", pop_vc0, 0);
    check("t2_c3_valid", valid_out, 1);
    check("t2_c3_data", data_out, 6'h14);
    tick();
    check("t2_c4_busy", busy, 0);
    check("t2_c4_valid", valid_out, 0);
    check("t2_c4_data", data_out, 6'h14);

    // Test 3: both FIFOs continuously non-empty -> 4:1 grant pattern
    do_reset();
    refill0 = 1'b1;
    refill1 = 1'b1;
    drive_fifo();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t3_pop0", pop_vc0, (pat[i] == 0) ? 1 : 0);
      check("t3_pop1", pop_vc1, (pat[i] == 1) ? 1 : 0);
      exp_q.push_back((pat[i] == 1) ? 6'h32 : q0[0]);
      tick();
      check("t3_valid", valid_out, 1);
      check("t3_grant", grant_vc, pat[i]);
      check("t3_data", data_out, exp_q.pop_front());
    end

    // Test 4: stall for 2 cycles after the 2nd VC0 grant keeps the count
    do_reset();
    for (int i = 1; i <= 6; i++) q0.push_back(6'(i));
    q1.push_back(6'h32);
    drive_fifo();
    tick();
    check("t4_c1_pop0", pop_vc0, 1);
    tick();
    check("t4_c2_pop0", pop_vc0, 1);
    tick();
    out_almost_full = 1'b1;
    #1;
    check("t4_c3_pop0", pop_vc0, 0);
    check("t4_c3_valid", valid_out, 1);
    check("t4_c3_data", data_out, 6'h02);
    tick();
    check("t4_c4_pop0", pop_vc0, 0);
    check("t4_c4_valid", valid_out, 0);
    tick();
    out_almost_full = 1'b0;
    #1;
    check("t4_c5_valid", valid_out, 0);
    check("t4_c5_pop0", pop_vc0, 1);
    tick();
    check("t4_c6_pop0", pop_vc0, 1);
    check("t4_c6_data", data_out, 6'h03);
    tick();
    check("t4_c7_pop0", pop_vc0, 0);
    check("t4_c7_pop1", pop_vc1, 1);
    check("t4_c7_data", data_out, 6'h04);
    tick();
    check("t4_c8_grant", grant_vc, 1);
    check("t4_c8_data", data_out, 6'h32);

    // Test 5: VC0 runs dry mid-burst, VC1 waiting
    do_reset();
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h33);
    drive_fifo();
    tick();
    tick();
    tick();
    check("t5_c3_state", dbg_state, 1);
    check("t5_c3_pop0", pop_vc0, 0);
    check("t5_c3_pop1", pop_vc1, 0);
    tick();
    check("t5_c4_state", dbg_state, 2);
    check("t5_c4_pop1", pop_vc1, 1);
    tick();
    check("t5_c5_valid", valid_out, 1);
    check("t5_c5_data", data_out, 6'h33);
    check("t5_c5_grant", grant_vc, 1);
    tick();
    check("t5_c6_state", dbg_state, 0);

    // Test 6: asynchronous reset between edges mid-burst
    do_reset();
    for (int i = 1; i <= 4; i++) q0.push_back(6'h20 + 6'(i));
    drive_fifo();
    tick();
    tick();
    tick();
    check("t6_pre_data", data_out, 6'h22);
    #1;
    reset = 1'b1;
    q1.push_back(6'h35);
    drive_fifo();
    #1;
    check("t6_async_valid", valid_out, 0);
    check("t6_async_data", data_out, 0);
    check("t6_async_pop0", pop_vc0, 0);
    check("t6_async_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("t6_c0_state", dbg_state, 0);
    tick();
    check("t6_c1_pop0", pop_vc0, 1);
    check("t6_c1_pop1", pop_vc1, 0);
    tick();
    check("t6_c2_data", data_out, 6'h23);
    check("t6_c2_grant", grant_vc, 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
